batch_reverse_buffer: RTL and testbench
=======================================

// Module: batch_reverse_buffer
// PURPOSE
//  Writer side of the batch lookahead path.
//  - Takes one downsampled control-sample word per enable strobe, in forward (time) order.
//  - Stores a batch of DEPTH words in a ping-pong memory of two banks.
//  - During the next batch, re-emits the stored words in reverse order.
//  - The batch filter reads this reversed stream as the lookahead/backward input.
//  - Sample written at batch index i appears when bat_count_rev == i one batch later.
// PARAMETERS
//  DEPTH  32  samples per batch (>=2, need not be a power of two)
//  WIDTH  4   bits per sample word (N*OSR of the filter)
// PORTS
//  clk            in   1                system clock, rising edge
//  rst            in   1                asynchronous reset, active-low
//  en             in   1                sample strobe; one word accepted per high cycle
//  din            in   WIDTH            forward-order sample word
//  dout           out  WIDTH            reverse-order word from the previous batch
//  out_valid      out  1                dout holds real data (first batch fully written)
//  bat_count      out  $clog2(DEPTH)    write index within the current batch
//  bat_count_rev  out  $clog2(DEPTH)    DEPTH-1-bat_count
//  cycle_pulse    out  1                high for one cycle on the strobe that wraps the batch
//  bank           out  1                current write bank; read bank is ~bank
// BEHAVIOUR
//  Reset (rst=0, async):
//   - bat_count=0, bat_count_rev=DEPTH-1, bank=0.
//   - dout=0, out_valid=0, cycle_pulse=0.
//   - Memory is not cleared.
//  Per rising clk edge with en=1 (c = bat_count before the edge):
//   - mem[bank][c] <= din.
//   - dout <= mem[~bank][DEPTH-1-c]  (registered read, one-edge latency).
//   - If c==DEPTH-1:
//     - bat_count<=0, bank<=~bank, cycle_pulse<=1.
//     - out_valid<=1 (sticky until reset).
//   - Else: bat_count<=c+1, cycle_pulse<=0.
//  Per rising clk edge with en=0:
//   - All state and outputs hold.
//   - Exception: cycle_pulse<=0.
//  bat_count_rev:
//   - Combinational DEPTH-1-bat_count.
//   - Never out of range for non-power-of-two DEPTH.
//  Latency: word written at strobe with index i (batch k) is on dout after the strobe
//   with index DEPTH-1-i in batch k+1, i.e. 2*DEPTH-1-2*i strobes later.
//  Read and write always address opposite banks; no read/write hazard in any cycle.
//  Wrap: explicit compare against DEPTH-1; counter never reaches DEPTH.
//  Before the first wrap:
//   - dout is updated from unwritten memory.
//   - out_valid=0 marks it invalid; consumers must gate on out_valid.
//  Reset mid-batch:
//   - Partial batch is discarded; counting restarts at index 0 bank 0.
//   - out_valid stays 0 until DEPTH new strobes have been taken.
// CONFIGURATION
//  BATCH_FWD_DELAY_EN defined:
//   - Adds output fwd_dout[WIDTH], reset 0.
//   - On each strobe, fwd_dout <= mem[~bank][c].
//   - Gives an exact one-batch forward-order delay for the forward mean path.
//   - Gated by the same out_valid.
//  Not defined: port and logic absent; behaviour otherwise identical.
// TESTING (DEPTH=4, WIDTH=8 unless stated)
//  1. Reset, en=1 every cycle, din=00..07 -> out_valid rises at 4th strobe;
//     dout after strobes 5..8 = 03,02,01,00.
//  2. Same data, en high every 3rd cycle only -> identical dout sequence;
//     all outputs stable between strobes.
//  3. Continuous strobes -> cycle_pulse high exactly one cycle when bat_count was 3;
//     bank toggles at each wrap; bat_count_rev = 3-bat_count always.
//  4. rst low after 6 strobes -> outputs zero immediately;
//     after release, out_valid=0 until 4 new strobes; no stale 04/05 on dout.
//  5. DEPTH=5, din=00..09 -> bat_count sequence 0..4,0; dout after strobes 6..10 = 04,03,02,01,00.
//  6. BATCH_FWD_DELAY_EN, test-1 stimulus -> fwd_dout after strobes 5..8 = 00,01,02,03.

Source files
------------

// File: rtl/batch_reverse_buffer.sv
// batch_reverse_buffer: writer side of the batch lookahead path.
// Takes one sample word per enable strobe in time order. Each batch of DEPTH words
// is stored in one bank of a two-bank ping-pong memory. During the next batch the
// stored words come back out in reverse order.
// Optional feature macro: BATCH_FWD_DELAY_EN adds o_fwd_dout, which gives a
// one-batch delay of the input stream in forward order.
module batch_reverse_buffer #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_out_valid,
    output logic [$clog2(DEPTH)-1:0] o_bat_count,
    output logic [$clog2(DEPTH)-1:0] o_bat_count_rev,
    output logic                     o_cycle_pulse,
`ifdef BATCH_FWD_DELAY_EN
    output logic [WIDTH-1:0]         o_fwd_dout,
`endif
    output logic                     o_bank
);

    localparam int unsigned CW   = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [2][DEPTH];

    logic [CW-1:0]    r_bat_count;
    logic             r_bank;
    logic [WIDTH-1:0] r_dout;
    logic             r_out_valid;
    logic             r_cycle_pulse;

    logic             w_wrap;
    logic             w_rd_bank;
    logic [CW-1:0]    w_rev_idx;

    // The counter is compared against DEPTH-1 directly, so it never leaves 0..DEPTH-1
    // even when DEPTH is not a power of two.
    assign w_wrap    = (r_bat_count == LAST);
    assign w_rd_bank = ~r_bank;
    assign w_rev_idx = LAST - r_bat_count;

    // Sample memory. It has no reset, so stale contents are masked by out_valid.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_bank][r_bat_count] <= i_din;
        end
    end

    // Reverse-order read from the bank that is not being written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout <= '0;
        end else if (i_en) begin
            r_dout <= r_mem[w_rd_bank][w_rev_idx];
        end
    end

`ifdef BATCH_FWD_DELAY_EN
    logic [WIDTH-1:0] r_fwd_dout;

    // Forward-order read of the previous batch, giving an exact one-batch delay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fwd_dout <= '0;
        end else if (i_en) begin
            r_fwd_dout <= r_mem[w_rd_bank][r_bat_count];
        end
    end

    assign o_fwd_dout = r_fwd_dout;
`endif

    // Batch index, bank toggle, wrap pulse and the sticky valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bat_count   <= '0;
            r_bank        <= 1'b0;
            r_out_valid   <= 1'b0;
            r_cycle_pulse <= 1'b0;
        end else if (i_en) begin
            if (w_wrap) begin
                r_bat_count   <= '0;
                r_bank        <= ~r_bank;
                r_out_valid   <= 1'b1;
                r_cycle_pulse <= 1'b1;
            end else begin
                r_bat_count   <= r_bat_count + CW'(1);
                r_cycle_pulse <= 1'b0;
            end
        end else begin
            r_cycle_pulse <= 1'b0;
        end
    end

    assign o_dout          = r_dout;
    assign o_out_valid     = r_out_valid;
    assign o_bat_count     = r_bat_count;
    assign o_bat_count_rev = w_rev_idx;
    assign o_cycle_pulse   = r_cycle_pulse;
    assign o_bank          = r_bank;

endmodule

// File: tb/tb_batch_reverse_buffer.sv
// Bench for batch_reverse_buffer.
// Two instances (DEPTH=4 and DEPTH=5, WIDTH=8) receive the same stimulus. A
// history-based model predicts every output on every cycle. Literal checks pin
// the model against hand-computed values.
module tb_batch_reverse_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] din = 8'h00;
    bit         chk_on = 1'b0;

    logic [7:0] dout_a, dout_b;
    logic       valid_a, valid_b, pulse_a, pulse_b, bank_a, bank_b;
    logic [1:0] cnt_a, rev_a;
    logic [2:0] cnt_b, rev_b;
    logic [7:0] fwd_a, fwd_b;

    int total = 0;
    int bad   = 0;

    batch_reverse_buffer #(.DEPTH(4), .WIDTH(8)) u_dut_a (
        .clk(clk), .rst(rst), .i_en(en), .i_din(din),
        .o_dout(dout_a), .o_out_valid(valid_a),
        .o_bat_count(cnt_a), .o_bat_count_rev(rev_a),
        .o_cycle_pulse(pulse_a),
`ifdef BATCH_FWD_DELAY_EN
        .o_fwd_dout(fwd_a),
`endif
        .o_bank(bank_a)
    );

    batch_reverse_buffer #(.DEPTH(5), .WIDTH(8)) u_dut_b (
        .clk(clk), .rst(rst), .i_en(en), .i_din(din),
        .o_dout(dout_b), .o_out_valid(valid_b),
        .o_bat_count(cnt_b), .o_bat_count_rev(rev_b),
        .o_cycle_pulse(pulse_b),
`ifdef BATCH_FWD_DELAY_EN
        .o_fwd_dout(fwd_b),
`endif
        .o_bank(bank_b)
    );

`ifndef BATCH_FWD_DELAY_EN
    assign fwd_a = 8'h00;
    assign fwd_b = 8'h00;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist holds every word accepted since reset. Strobe n falls in batch n/D at
    // index n%D. It reads back history entry (batch-1)*D + (D-1-index).
    logic [7:0] hist[$];
    int n = 0;
    int e_dout[2];
    int e_fwd[2];
    int e_pulse[2];
    bit e_known[2];

    function automatic int dep(input int i);
        return (i == 0) ? 4 : 5;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            n = 0;
            hist.delete();
            for (int i = 0; i < 2; i++) begin
                e_dout[i]  = 0;
                e_fwd[i]   = 0;
                e_pulse[i] = 0;
                e_known[i] = 1'b1;
            end
        end else if (en) begin
            for (int i = 0; i < 2; i++) begin
                int d, c, k;
                d = dep(i);
                c = n % d;
                k = n / d;
                if (k >= 1) begin
                    e_dout[i]  = 32'(hist[(k - 1) * d + (d - 1 - c)]);
                    e_fwd[i]   = 32'(hist[(k - 1) * d + c]);
                    e_known[i] = 1'b1;
                end else begin
                    e_known[i] = 1'b0;
                end
                e_pulse[i] = (c == d - 1) ? 1 : 0;
            end
            hist.push_back(din);
            n++;
        end else begin
            for (int i = 0; i < 2; i++) e_pulse[i] = 0;
        end
    end

    task automatic cmp(input int i, input int dout, input int valid, input int cnt,
                       input int rev, input int pulse, input int bank, input int fwd);
        int d;
        string p;
        d = dep(i);
        p = $sformatf("d%0d_", d);
        chk({p, "out_valid"}, valid, (n >= d) ? 1 : 0);
        chk({p, "bat_count"}, cnt, n % d);
        chk({p, "bat_count_rev"}, rev, d - 1 - (n % d));
        chk({p, "cycle_pulse"}, pulse, e_pulse[i]);
        chk({p, "bank"}, bank, (n / d) % 2);
        if (e_known[i]) begin
            chk({p, "dout"}, dout, e_dout[i]);
`ifdef BATCH_FWD_DELAY_EN
            chk({p, "fwd_dout"}, fwd, e_fwd[i]);
`endif
        end
`ifndef BATCH_FWD_DELAY_EN
        if (fwd != 0) $display("unexpected fwd value %0h", fwd);
`endif
    endtask

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            cmp(0, 32'(dout_a), 32'(valid_a), 32'(cnt_a), 32'(rev_a), 32'(pulse_a), 32'(bank_a), 32'(fwd_a));
            cmp(1, 32'(dout_b), 32'(valid_b), 32'(cnt_b), 32'(rev_b), 32'(pulse_b), 32'(bank_b), 32'(fwd_b));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic e, input logic [7:0] d);
        en  = e;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rst_dout_a"},  32'(dout_a), 0);
        chk({tag, "_rst_valid_a"}, 32'(valid_a), 0);
        chk({tag, "_rst_cnt_a"},   32'(cnt_a), 0);
        chk({tag, "_rst_rev_a"},   32'(rev_a), 3);
        chk({tag, "_rst_bank_a"},  32'(bank_a), 0);
        chk({tag, "_rst_pulse_a"}, 32'(pulse_a), 0);
        chk({tag, "_rst_rev_b"},   32'(rev_b), 4);
        chk({tag, "_rst_dout_b"},  32'(dout_b), 0);
    endtask

    task automatic do_reset(input string tag);
        en  = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_outputs(tag);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        rst = 1'b1;
    endtask

    initial begin
        #2;
        do_reset("init");
        chk_on = 1'b1;

        // Continuous strobes, din = 00..09.
        for (int s = 1; s <= 10; s++) begin
            step(1'b1, 8'(s - 1));
            if (s == 3) chk("t1_valid_before_wrap", 32'(valid_a), 0);
            if (s == 4) begin
                chk("t1_valid_at_wrap", 32'(valid_a), 1);
                chk("t3_pulse_at_wrap", 32'(pulse_a), 1);
                chk("t3_bank_after_wrap", 32'(bank_a), 1);
                chk("t3_cnt_after_wrap", 32'(cnt_a), 0);
            end
            if (s == 5) chk("t3_pulse_after", 32'(pulse_a), 0);
            if (s == 8) chk("t3_bank_second_wrap", 32'(bank_a), 0);
            if (s >= 5 && s <= 8) chk("t1_dout_lit", 32'(dout_a), 8 - s);
            if (s <= 5) chk("t5_cnt_lit", 32'(cnt_b), s % 5);
            if (s >= 6 && s <= 10) chk("t5_dout_lit", 32'(dout_b), 10 - s);
`ifdef BATCH_FWD_DELAY_EN
            if (s >= 5 && s <= 8) chk("t6_fwd_lit", 32'(fwd_a), s - 5);
`endif
        end
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);

        // Strobe every third cycle; outputs must hold in the gaps.
        do_reset("t2");
        for (int s = 1; s <= 8; s++) begin
            step(1'b1, 8'(s - 1));
            if (s >= 5) chk("t2_dout_lit", 32'(dout_a), 8 - s);
            step(1'b0, 8'hAA);
            step(1'b0, 8'h55);
            if (s >= 5) chk("t2_dout_hold", 32'(dout_a), 8 - s);
            if (s == 4) chk("t2_pulse_gap", 32'(pulse_a), 0);
        end

        // Reset in the middle of a batch: the partial batch must not reappear.
        do_reset("t4a");
        for (int s = 1; s <= 6; s++) step(1'b1, 8'(8'h40 + s - 1));
        do_reset("t4");
        for (int s = 1; s <= 8; s++) begin
            step(1'b1, 8'(8'h10 + s - 1));
            if (s <= 3) chk("t4_valid_low", 32'(valid_a), 0);
            if (s == 4) chk("t4_valid_high", 32'(valid_a), 1);
            if (s >= 5) chk("t4_dout_lit", 32'(dout_a), 8'h18 - s);
        end

        // Irregular strobe pattern checked by the model alone.
        for (int s = 0; s < 60; s++) begin
            step((s % 5) != 2, 8'(s * 7 + 3));
        end
        step(1'b0, 8'h00);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
